blockade_video_timing: RTL and testbench
========================================

BLOCKADE_VIDEO_TIMING -- requirements
Module: blockade_video_timing

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_DIV, 10: clk cycles per pixel enable, legal range 2..16.
- CE_PHASE, 0: divider count on which ce_pix fires, 0..CLK_DIV-1.
- CW, 9: width of the h and v counters.
- H_TOTAL, 330: pixels per line.
- H_BLANK_START, 256: first blanked pixel.
- H_SYNC_START, 272; H_SYNC_END, 300: first sync pixel; first pixel after sync.
- V_TOTAL, 262: lines per frame.
- V_BLANK_START, 224: first blanked line.
- V_SYNC_START, 254; V_SYNC_END, 261: first sync line; first line after sync.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  reset, asynchronous and active-low.
- enable  in  1  run/pause; when low the divider and all counters hold.
- sync_pol  in  2  [0] inverts hsync, [1] inverts vsync; sampled combinationally at the outputs.
- ce_pix  out  1  pixel clock enable.
- hcnt  out  CW  horizontal position.
- vcnt  out  CW  vertical position.
- hblank, vblank, hsync, vsync  out  1 each  timing strobes, active-high before polarity.
- line_start  out  1  one-clk pulse.
- frame_start  out  1  one-clk pulse.
- vblank_irq  out  1  one-clk pulse.
- frame_cnt  out  8  frames completed.
- cpu_vram_req  in  1  CPU requests a VRAM cycle.
- cpu_ready  out  1  CPU READY; low means wait state.
REQ-003 Elaboration SHALL fail if any of the following does not hold: H_BLANK_START < H_SYNC_START < H_SYNC_END <= H_TOTAL; V_BLANK_START < V_SYNC_START < V_SYNC_END <= V_TOTAL; H_TOTAL and V_TOTAL <= 2^CW.

Function
REQ-004 A divider SHALL count 0..CLK_DIV-1 and wrap, advancing once per clk while enable=1.
REQ-005 ce_pix SHALL be high for exactly one clk, on the cycle the divider count equals CE_PHASE and enable=1; it SHALL never be high otherwise.
REQ-006 On each ce_pix, hcnt SHALL increment; it SHALL wrap from H_TOTAL-1 to 0.
REQ-007 vcnt SHALL increment only on the ce_pix where hcnt wraps; it SHALL wrap from V_TOTAL-1 to 0 on that same ce_pix.
REQ-008 All strobes SHALL be registered and updated on the same clk as the counters, so they decode the new counter values with zero skew:
- hblank = hcnt >= H_BLANK_START.
- hsync = H_SYNC_START <= hcnt < H_SYNC_END.
- vblank = vcnt >= V_BLANK_START.
- vsync = V_SYNC_START <= vcnt < V_SYNC_END.
REQ-009 Output hsync SHALL be the internal hsync XOR sync_pol[0]; output vsync SHALL be the internal vsync XOR sync_pol[1].
REQ-010 line_start SHALL pulse on the ce_pix that sets hcnt to 0.
REQ-011 frame_start SHALL pulse on the ce_pix that sets both hcnt and vcnt to 0, coincident with line_start.
REQ-012 vblank_irq SHALL pulse on the ce_pix where vblank rises 0->1.
REQ-013 frame_cnt SHALL increment modulo 256 on each frame_start.
REQ-014 The cpu_ready state machine SHALL have three states:
- FREE: cpu_ready=1.
- WAIT: cpu_ready=0.
- GRANT: cpu_ready=1 for one clk.
REQ-015 cpu_ready transitions SHALL be:
- FREE->WAIT when cpu_vram_req=1 and vblank=0.
- WAIT->GRANT on the first clk with vblank=1.
- GRANT->FREE unconditionally.
- Any state with cpu_vram_req=0 -> FREE, except GRANT.
REQ-016 A request in the same clk that vblank rises SHALL see the registered vblank=1 and remain in FREE (no wait).
REQ-017 A request that starts while vblank=1 SHALL get cpu_ready=1 with zero wait.
REQ-018 When enable=0, the state machine SHALL hold its state, and no pulses SHALL be emitted.

Reset
REQ-019 While reset_n=0, asynchronously, the following SHALL be cleared:
- divider=0, hcnt=0, vcnt=0, frame_cnt=0.
- hblank, vblank, internal hsync and internal vsync = 0.
- All pulses = 0.
- state=FREE, so cpu_ready=1.
REQ-020 Reset release SHALL be synchronous to clk.
REQ-021 The first ce_pix after reset SHALL occur CE_PHASE+1 clks after release with enable=1.
REQ-022 On that first ce_pix, hcnt SHALL become 1.
REQ-023 Reset asserted mid-frame SHALL abort any WAIT without emitting a GRANT pulse.

Verification
REQ-024 Defaults, enable=1, one full frame: exactly 330*262=86460 ce_pix; ce_pix spacing 10 clks; hblank high for 74 pixels/line; hsync high for hcnt 272..299; vblank first high at vcnt=224; vsync high for vcnt 254..260; exactly 1 frame_start, 262 line_start, 1 vblank_irq; frame_cnt=1.
REQ-025 Wrap check: at hcnt=329, vcnt=261, the next ce_pix gives hcnt=0, vcnt=0, line_start=frame_start=1 in the same clk.
REQ-026 Arbitration: cpu_vram_req=1 at vcnt=10 -> cpu_ready=0 until vcnt reaches 224; a single GRANT clk follows; then, with cpu_vram_req held, cpu_ready stays 1 throughout vblank.
REQ-027 Pause/polarity: enable=0 for 50 clks -> hcnt, vcnt and ce_pix frozen, no pulses; sync_pol=2'b11 -> hsync and vsync idle high and go low during sync.
REQ-028 Reset_n pulsed low at vcnt=100 while in WAIT -> all outputs return to their reset values immediately, with cpu_ready=1.
REQ-029 A parameter sweep with CLK_DIV=2, CE_PHASE=1, H_TOTAL=64, V_TOTAL=32 SHALL reproduce REQ-024 and REQ-025 scaled to those values.

Source files
------------

// File: rtl/blockade_video_timing.sv
`timescale 1ns / 1ps
// Blockade-style raster timing: pixel-enable divider, h/v counters with zero-skew registered
// strobes and pulses, and a CPU VRAM wait-state arbiter that releases the CPU during vblank.
module blockade_video_timing #(
   parameter int CLK_DIV       = 10,
   parameter int CE_PHASE      = 0,
   parameter int CW            = 9,
   parameter int H_TOTAL       = 330,
   parameter int H_BLANK_START = 256,
   parameter int H_SYNC_START  = 272,
   parameter int H_SYNC_END    = 300,
   parameter int V_TOTAL       = 262,
   parameter int V_BLANK_START = 224,
   parameter int V_SYNC_START  = 254,
   parameter int V_SYNC_END    = 261
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [1:0]    sync_pol,
   output logic          ce_pix,
   output logic [CW-1:0] hcnt,
   output logic [CW-1:0] vcnt,
   output logic          hblank,
   output logic          vblank,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic          vblank_irq,
   output logic [7:0]    frame_cnt,
   input  logic          cpu_vram_req,
   output logic          cpu_ready
);

   if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_clk_div
      $error("CLK_DIV must be in 2..16");
   end
   if (CE_PHASE < 0 || CE_PHASE >= CLK_DIV) begin : g_bad_ce_phase
      $error("CE_PHASE must be in 0..CLK_DIV-1");
   end
   if (!(H_BLANK_START < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
      $error("horizontal timing must satisfy blank < sync_start < sync_end <= total");
   end
   if (!(V_BLANK_START < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
      $error("vertical timing must satisfy blank < sync_start < sync_end <= total");
   end
   if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
      $error("H_TOTAL and V_TOTAL must fit in CW-bit counters");
   end

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] CE_AT    = DW'(CE_PHASE);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   // Decode thresholds are one bit wider so a sync end equal to 2^CW stays representable.
   localparam logic [CW:0]   HB_S     = (CW+1)'(H_BLANK_START);
   localparam logic [CW:0]   HS_S     = (CW+1)'(H_SYNC_START);
   localparam logic [CW:0]   HS_E     = (CW+1)'(H_SYNC_END);
   localparam logic [CW:0]   VB_S     = (CW+1)'(V_BLANK_START);
   localparam logic [CW:0]   VS_S     = (CW+1)'(V_SYNC_START);
   localparam logic [CW:0]   VS_E     = (CW+1)'(V_SYNC_END);

   typedef enum logic [1:0] {
      ST_FREE,
      ST_WAIT,
      ST_GRANT
   } arb_state_e;

   logic [DW-1:0] div_q, div_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] vcnt_q, vcnt_d;
   logic [CW:0]   h_ext, v_ext;
   logic          hblank_q, hblank_d, hsync_q, hsync_d;
   logic          vblank_q, vblank_d, vsync_q, vsync_d;
   logic          ce_q, line_q, frame_q, irq_q;
   logic [7:0]    fcnt_q, fcnt_d;
   logic          tick, hwrap, vwrap;
   arb_state_e    state_q, state_d;

   assign tick  = enable && (div_q == CE_AT);
   assign hwrap = (hcnt_q == H_LAST);
   assign vwrap = (vcnt_q == V_LAST);

   // NOTE: every output of this block gets a default before any branch, so no path infers a latch.
   always_comb begin
      div_d  = div_q;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      fcnt_d = fcnt_q;
      if (enable) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (tick) begin
         hcnt_d = hwrap ? '0 : hcnt_q + CW'(1);
         if (hwrap) begin
            vcnt_d = vwrap ? '0 : vcnt_q + CW'(1);
            if (vwrap) begin
               fcnt_d = fcnt_q + 8'd1;
            end
         end
      end
      // Strobes decode the next counter values so they land on the same edge as the counters.
      h_ext    = {1'b0, hcnt_d};
      v_ext    = {1'b0, vcnt_d};
      hblank_d = (h_ext >= HB_S);
      hsync_d  = (h_ext >= HS_S) && (h_ext < HS_E);
      vblank_d = (v_ext >= VB_S);
      vsync_d  = (v_ext >= VS_S) && (v_ext < VS_E);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q    <= '0;
         hcnt_q   <= '0;
         vcnt_q   <= '0;
         fcnt_q   <= '0;
         hblank_q <= 1'b0;
         hsync_q  <= 1'b0;
         vblank_q <= 1'b0;
         vsync_q  <= 1'b0;
         ce_q     <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         fcnt_q  <= fcnt_d;
         ce_q    <= tick;
         line_q  <= tick && hwrap;
         frame_q <= tick && hwrap && vwrap;
         irq_q   <= tick && vblank_d && !vblank_q;
         if (tick) begin
            hblank_q <= hblank_d;
            hsync_q  <= hsync_d;
            vblank_q <= vblank_d;
            vsync_q  <= vsync_d;
         end
      end
   end

   // The arbiter looks only at registered vblank, so a request in the rising cycle sees it high.
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            ST_FREE: begin
               if (cpu_vram_req && !vblank_q) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (!cpu_vram_req)  state_d = ST_FREE;
               else if (vblank_q)  state_d = ST_GRANT;
            end
            ST_GRANT: state_d = ST_FREE;
            default:  state_d = ST_FREE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_FREE;
      else          state_q <= state_d;
   end

   assign ce_pix      = ce_q;
   assign hcnt        = hcnt_q;
   assign vcnt        = vcnt_q;
   assign hblank      = hblank_q;
   assign vblank      = vblank_q;
   assign hsync       = hsync_q ^ sync_pol[0];
   assign vsync       = vsync_q ^ sync_pol[1];
   assign line_start  = line_q;
   assign frame_start = frame_q;
   assign vblank_irq  = irq_q;
   assign frame_cnt   = fcnt_q;
   assign cpu_ready   = (state_q != ST_WAIT);

endmodule

// File: tb/tb_blockade_video_timing.sv
`timescale 1ns / 1ps
// Scoreboard bench for blockade_video_timing on a shrunken raster (64x32 pixels, CLK_DIV=2):
// expected pixels are queued by the stimulus and checked by a monitor on every ce_pix.
module tb_blockade_video_timing;

   localparam int CLK_DIV       = 2;
   localparam int CE_PHASE      = 1;
   localparam int CW            = 6;
   localparam int H_TOTAL       = 64;
   localparam int H_BLANK_START = 48;
   localparam int H_SYNC_START  = 52;
   localparam int H_SYNC_END    = 64;
   localparam int V_TOTAL       = 32;
   localparam int V_BLANK_START = 24;
   localparam int V_SYNC_START  = 28;
   localparam int V_SYNC_END    = 31;
   localparam int FRAME         = H_TOTAL * V_TOTAL;

   typedef struct packed {
      logic [CW-1:0] h;
      logic [CW-1:0] v;
      logic          hb, vb, hs, vs, ls, fs, irq;
      logic [7:0]    fc;
   } pix_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    sync_pol = 2'b00;
   logic          cpu_vram_req = 1'b0;
   logic          ce_pix, hblank, vblank, hsync, vsync;
   logic          line_start, frame_start, vblank_irq, cpu_ready;
   logic [CW-1:0] hcnt, vcnt;
   logic [7:0]    frame_cnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   pix_t sb_q[$];
   int   m_pix = 0;
   int   en_cnt = 0, last_en = 0;
   bit   first_ce = 1'b1;
   int   ce_seen = 0, ls_cnt = 0, fs_cnt = 0, irq_cnt = 0;
   int   hb_cnt = 0, hs_cnt = 0, vs_cnt = 0;

   blockade_video_timing #(
      .CLK_DIV(CLK_DIV), .CE_PHASE(CE_PHASE), .CW(CW),
      .H_TOTAL(H_TOTAL), .H_BLANK_START(H_BLANK_START),
      .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
      .V_TOTAL(V_TOTAL), .V_BLANK_START(V_BLANK_START),
      .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .sync_pol(sync_pol),
      .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
      .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
      .line_start(line_start), .frame_start(frame_start), .vblank_irq(vblank_irq),
      .frame_cnt(frame_cnt), .cpu_vram_req(cpu_vram_req), .cpu_ready(cpu_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Raster position of the p-th pixel enable since reset (the first one lands on hcnt=1).
   function automatic pix_t model(input int p);
      pix_t e;
      int   h, v;
      h     = p % H_TOTAL;
      v     = (p / H_TOTAL) % V_TOTAL;
      e.h   = CW'(h);
      e.v   = CW'(v);
      e.hb  = (h >= H_BLANK_START);
      e.hs  = (h >= H_SYNC_START) && (h < H_SYNC_END);
      e.vb  = (v >= V_BLANK_START);
      e.vs  = (v >= V_SYNC_START) && (v < V_SYNC_END);
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      e.irq = (h == 0) && (v == V_BLANK_START);
      e.fc  = 8'((p / FRAME) % 256);
      return e;
   endfunction

   task automatic run_pixels(input int n);
      int k;
      for (int i = 1; i <= n; i++) sb_q.push_back(model(m_pix + i));
      m_pix += n;
      k = 0;
      while (sb_q.size() != 0 && k < n * CLK_DIV + 64) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_pixels_timeout: got %0d pixels outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   always @(posedge clk) begin
      if (reset_n && enable) en_cnt++;
   end

   always @(negedge clk) begin
      pix_t a, e;
      if (!reset_n) begin
         first_ce = 1'b1;
         last_en  = en_cnt;
      end else if (ce_pix) begin
         check(first_ce ? "first_ce_latency" : "ce_spacing", en_cnt - last_en,
               first_ce ? CE_PHASE + 1 : CLK_DIV);
         first_ce = 1'b0;
         last_en  = en_cnt;
         ce_seen++;
         ls_cnt  += int'(line_start);
         fs_cnt  += int'(frame_start);
         irq_cnt += int'(vblank_irq);
         hb_cnt  += int'(hblank);
         hs_cnt  += int'(hsync ^ sync_pol[0]);
         vs_cnt  += int'(vsync ^ sync_pol[1]);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ce_pix: got ce_pix=1 at hcnt=%0d vcnt=%0d, expected none", hcnt, vcnt);
         end else begin
            e    = sb_q.pop_front();
            e.hs = e.hs ^ sync_pol[0];
            e.vs = e.vs ^ sync_pol[1];
            a    = '{h: hcnt, v: vcnt, hb: hblank, vb: vblank, hs: hsync, vs: vsync,
                     ls: line_start, fs: frame_start, irq: vblank_irq, fc: frame_cnt};
            check($sformatf("pixel h%0d v%0d", e.h, e.v), 32'(a), 32'(e));
         end
      end else if (line_start || frame_start || vblank_irq) begin
         n_checks++;
         n_fail++;
         $display("FAIL pulse_without_ce: got ls/fs/irq=%b%b%b, expected 000", line_start, frame_start, vblank_irq);
      end
   end

   initial begin
      pix_t e;
      int   ce_snap, k;
      bit   saw;

      // Reset state
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_counters", {hcnt, vcnt}, '0);
      check("reset_strobes", {hblank, vblank, hsync, vsync}, 4'b0000);
      check("reset_pulses", {ce_pix, line_start, frame_start, vblank_irq}, 4'b0000);
      check("reset_frame_cnt", frame_cnt, 8'd0);
      check("reset_cpu_ready", cpu_ready, 1'b1);
      reset_n = 1'b1;
      enable  = 1'b1;

      // One full frame, ending on the (63,31) -> (0,0) wrap
      run_pixels(FRAME);
      check("frame_ce_count", ce_seen, FRAME);
      check("frame_line_starts", ls_cnt, V_TOTAL);
      check("frame_frame_starts", fs_cnt, 1);
      check("frame_vblank_irqs", irq_cnt, 1);
      check("frame_hblank_pixels", hb_cnt, (H_TOTAL - H_BLANK_START) * V_TOTAL);
      check("frame_hsync_pixels", hs_cnt, (H_SYNC_END - H_SYNC_START) * V_TOTAL);
      check("frame_vsync_pixels", vs_cnt, (V_SYNC_END - V_SYNC_START) * H_TOTAL);
      check("frame_cnt_after_frame", frame_cnt, 8'd1);

      // Arbitration: request at line 10 waits until vblank, then stays ready through vblank
      run_pixels(10 * H_TOTAL);
      fork
         run_pixels((V_TOTAL - 10) * H_TOTAL);
         begin
            cpu_vram_req = 1'b1;
            saw = 1'b0;
            k   = 0;
            @(negedge clk);
            while (!vblank && k < 4 * FRAME) begin
               if (cpu_ready) saw = 1'b1;
               @(negedge clk);
               k++;
            end
            check("arb_vblank_reached", vblank, 1'b1);
            check("arb_ready_low_until_vblank", saw, 1'b0);
            check("arb_ready_at_vblank_rise", cpu_ready, 1'b0);
            @(negedge clk);
            check("arb_grant_ready", cpu_ready, 1'b1);
            saw = 1'b0;
            k   = 0;
            while (vblank && k < 4 * FRAME) begin
               if (!cpu_ready) saw = 1'b1;
               @(negedge clk);
               k++;
            end
            check("arb_ready_high_in_vblank", saw, 1'b0);
            check("arb_ready_at_vblank_end", cpu_ready, 1'b1);
            @(negedge clk);
            check("arb_rewait_after_vblank", cpu_ready, 1'b0);
         end
      join
      cpu_vram_req = 1'b0;

      // Inverted sync polarity, then a 50-clk pause inside hsync
      sync_pol = 2'b11;
      run_pixels(60);
      @(posedge clk);
      #1 enable = 1'b0;
      ce_snap = ce_seen;
      repeat (50) @(posedge clk);
      @(negedge clk);
      e = model(m_pix);
      check("pause_hcnt", hcnt, e.h);
      check("pause_vcnt", vcnt, e.v);
      check("pause_ce_count", ce_seen, ce_snap);
      check("pause_hsync_inverted", hsync, e.hs ^ 1'b1);
      check("pause_vsync_idle_high", vsync, e.vs ^ 1'b1);
      check("arb_free_after_drop", cpu_ready, 1'b1);
      enable = 1'b1;
      run_pixels(H_TOTAL - 60 + (V_BLANK_START - 1) * H_TOTAL);

      // Request in the cycle vblank rises and during vblank: no wait
      fork
         run_pixels((V_TOTAL - V_BLANK_START + 3) * H_TOTAL + 5);
         begin
            cpu_vram_req = 1'b1;
            @(negedge clk);
            check("req_at_vblank_rise_ready", cpu_ready, 1'b1);
            @(negedge clk);
            check("req_in_vblank_ready", cpu_ready, 1'b1);
         end
      join
      check("wait_before_reset", cpu_ready, 1'b0);

      // Mid-frame reset while waiting
      @(posedge clk);
      #1 reset_n = 1'b0;
      cpu_vram_req = 1'b0;
      #1;
      check("midrst_counters", {hcnt, vcnt}, '0);
      check("midrst_frame_cnt", frame_cnt, 8'd0);
      check("midrst_cpu_ready", cpu_ready, 1'b1);
      check("midrst_strobes", {hblank, vblank, hsync, vsync}, 4'b0011);
      check("midrst_pulses", {ce_pix, line_start, frame_start, vblank_irq}, 4'b0000);
      sb_q.delete();
      m_pix = 0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      run_pixels(H_TOTAL + 6);
      check("postrst_cpu_ready", cpu_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
